// File: rtl/color_conv_pipe_if.sv
// Stream bundle for color_conv_pipe: pixel input side (s_*) and converted output side (m_*).
// The slave modport is the converter's view; the master modport is the source/sink's view.
interface color_conv_pipe_if #(
    parameter int DATA_W = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [3*DATA_W-1:0]   s_data;
    logic                  s_last;
    logic [1:0]            s_mode;
    logic                  m_valid;
    logic                  m_ready;
    logic [3*DATA_W-1:0]   m_data;
    logic                  m_last;

    modport slave (
        input  s_valid, s_data, s_last, s_mode, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, s_mode, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/color_conv_pipe.sv
// 3-stage RGB -> YCbCr converter (BT.601 / BT.709 / bypass per pixel) with a global stall.
// Define COLOR_CONV_SAT_COUNT_EN to build the saturating clamp-event counter on sat_count.
module color_conv_pipe #(
    parameter int DATA_W    = 8,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    color_conv_pipe_if.slave     bus,
    output logic [SAT_CNT_W-1:0] sat_count
);
    localparam int PIX_W = 3 * DATA_W;
    localparam int FRAC  = 14;
    localparam int ACC_W = DATA_W + 20;

    typedef logic signed [15:0]      coef_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t OFFSET  = acc_t'(1) <<< (DATA_W - 1 + FRAC);
    localparam acc_t ROUND   = acc_t'(1) <<< (FRAC - 1);
    localparam acc_t PIX_MAX = acc_t'((1 << DATA_W) - 1);

    // [standard][output Y/Cb/Cr][input R/G/B], signed Q1.14
    localparam coef_t COEF [2][3][3] = '{
        '{ '{ 16'sd4899,   16'sd9617,   16'sd1868 },
           '{ -16'sd2764,  -16'sd5428,  16'sd8192 },
           '{ 16'sd8192,   -16'sd6860,  -16'sd1332 } },
        '{ '{ 16'sd3483,   16'sd11718,  16'sd1183 },
           '{ -16'sd1878,  -16'sd6314,  16'sd8192 },
           '{ 16'sd8192,   -16'sd7442,  -16'sd750 } }
    };

    function automatic logic is_bypass(input logic [1:0] mode);
        return mode >= 2'd2;
    endfunction

    logic             advance;
    logic             s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
    logic [1:0]       s1_mode_d, s1_mode_q;
    logic [PIX_W-1:0] s1_data_d, s1_data_q;
    logic             s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
    logic [1:0]       s2_mode_d, s2_mode_q;
    logic [PIX_W-1:0] s2_pix_d, s2_pix_q;
    acc_t             s2_acc_d [3];
    acc_t             s2_acc_q [3];
    logic             m_valid_d, m_valid_q, m_last_d, m_last_q;
    logic [PIX_W-1:0] m_data_d, m_data_q;
    acc_t             prod_sum [3];
    logic [2:0]       clamp_hit;
    logic [PIX_W-1:0] conv_pix;

    // Full-width multiply-accumulate of the S1 pixel; Cb/Cr carry the mid-scale offset.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            prod_sum[k] = (k == 0) ? '0 : OFFSET;
            for (int c = 0; c < 3; c++) begin
                prod_sum[k] = prod_sum[k]
                            + acc_t'(s1_data_q[c*DATA_W +: DATA_W]) * acc_t'(COEF[s1_mode_q[0]][k][c]);
            end
        end
    end

    always_comb begin
        acc_t rnd;
        logic neg, over;
        conv_pix  = '0;
        clamp_hit = '0;
        for (int k = 0; k < 3; k++) begin
            rnd  = (s2_acc_q[k] + ROUND) >>> FRAC;
            neg  = rnd[ACC_W-1];
            over = !neg && (rnd > PIX_MAX);
            clamp_hit[k] = neg | over;
            conv_pix[k*DATA_W +: DATA_W] = neg ? '0 : (over ? '1 : rnd[DATA_W-1:0]);
        end
    end

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
        advance    = !(m_valid_q && !bus.m_ready);
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_mode_d  = s2_mode_q;
        s2_pix_d   = s2_pix_q;
        s2_acc_d   = s2_acc_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        if (advance) begin
            s1_valid_d = bus.s_valid;
            s1_last_d  = bus.s_last;
            s1_mode_d  = bus.s_mode;
            s1_data_d  = bus.s_data;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_mode_d  = s1_mode_q;
            s2_pix_d   = s1_data_q;
            s2_acc_d   = prod_sum;
            m_valid_d  = s2_valid_q;
            m_last_d   = s2_last_q;
            m_data_d   = is_bypass(s2_mode_q) ? s2_pix_q : conv_pix;
        end
    end

    // NOTE: state flops use non-blocking assignments so every stage samples the pre-edge value of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= '0;
            s2_pix_q   <= '0;
            for (int k = 0; k < 3; k++) s2_acc_q[k] <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_mode_q  <= s2_mode_d;
            s2_pix_q   <= s2_pix_d;
            s2_acc_q   <= s2_acc_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
        end
    end

    assign bus.s_ready = advance;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_data  = m_data_q;

`ifdef COLOR_CONV_SAT_COUNT_EN
    logic                 m_clamp_d, m_clamp_q;
    logic [SAT_CNT_W-1:0] sat_count_d, sat_count_q;

    // Counts output beats (handshakes), not cycles a clamped pixel sits stalled.
    always_comb begin
        m_clamp_d   = m_clamp_q;
        sat_count_d = sat_count_q;
        if (advance) m_clamp_d = s2_valid_q && !is_bypass(s2_mode_q) && (|clamp_hit);
        if (m_valid_q && bus.m_ready && m_clamp_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clamp_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            m_clamp_q   <= m_clamp_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = '0;
`endif
endmodule

// File: tb/tb_color_conv_pipe.sv
// Scoreboard bench for color_conv_pipe (DATA_W=8): directed vectors, random stream with
// backpressure and mixed modes, and an asynchronous reset with pixels in flight.
module tb_color_conv_pipe;
    logic        clk;
    logic        rst_n;
    logic [15:0] sat_count;

    color_conv_pipe_if #(.DATA_W(8)) bus ();

    color_conv_pipe #(.DATA_W(8), .SAT_CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
        bit          clamp;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   exp_sat    = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never
    bit   lat_exact  = 1'b1;

    // Q1.14 tables [standard][Y/Cb/Cr][R/G/B]
    int coef_tab [2][3][3] = '{
        '{ '{4899, 9617, 1868},  '{-2764, -5428, 8192}, '{8192, -6860, -1332} },
        '{ '{3483, 11718, 1183}, '{-1878, -6314, 8192}, '{8192, -7442, -750} }
    };

    function automatic logic [23:0] ref_conv(input logic [23:0] pix, input logic [1:0] md,
                                             output bit clamped);
        int comp [3];
        int acc, v;
        logic [23:0] res;
        clamped = 1'b0;
        if (md >= 2) return pix;
        for (int c = 0; c < 3; c++) comp[c] = int'(pix[8*c +: 8]);
        res = '0;
        for (int k = 0; k < 3; k++) begin
            acc = (k == 0) ? 0 : 128 * 16384;
            for (int c = 0; c < 3; c++) acc += coef_tab[md[0]][k][c] * comp[c];
            v = (acc + 8192) >>> 14;
            if (v < 0) begin
                v = 0;
                clamped = 1'b1;
            end else if (v > 255) begin
                v = 255;
                clamped = 1'b1;
            end
            res[8*k +: 8] = v[7:0];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sole driver of m_ready; changes 1 time unit after each rising edge.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Presents a pixel from posedge+1 and holds it until the falling-edge sample shows s_ready.
    task automatic send_exp(input logic [23:0] d, input logic [1:0] md, input logic l,
                            input logic [23:0] expd, input bit expc);
        int   waitc = 0;
        exp_t e;
        bit   ok = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_mode  = md;
        bus.s_last  = l;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            waitc++;
            if (waitc > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL s_ready_timeout: s_ready stayed 0 for %0d cycles, expected 1", waitc);
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            e.data = expd;
            e.last = l;
            e.clamp = expc;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_model(input logic [23:0] d, input logic [1:0] md, input logic l);
        bit c;
        logic [23:0] r;
        r = ref_conv(d, md, c);
        send_exp(d, md, l, r, c);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops and compares on every output handshake, and checks hold-while-stalled.
    initial begin
        bit          held = 1'b0;
        logic [23:0] held_data = '0;
        logic        held_last = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_m_valid", bus.m_valid, 1);
                    check("stall_m_data", bus.m_data, held_data);
                    check("stall_m_last", bus.m_last, held_last);
                end
                if (bus.m_valid && bus.m_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out: got m_data 0x%0h, expected no output", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", bus.m_data, e.data);
                        check("m_last", bus.m_last, e.last);
                        if (lat_exact) check("latency", cyc - e.acc_cyc, 3);
                        else check("latency_min", (cyc - e.acc_cyc) >= 3, 1);
`ifdef COLOR_CONV_SAT_COUNT_EN
                        if (e.clamp && exp_sat < 65535) exp_sat++;
`endif
                    end
                end else if (bus.m_valid) begin
                    held = 1'b1;
                    held_data = bus.m_data;
                    held_last = bus.m_last;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_mode  = '0;
        bus.s_last  = 1'b0;
        #2;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_sat_count", sat_count, 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with the output always ready: exact 3-cycle latency
        lat_exact = 1'b1;
        send_exp(24'hFFFFFF, 2'd0, 1'b0, 24'h8080FF, 1'b0);
        send_exp(24'h000000, 2'd0, 1'b1, 24'h808000, 1'b0);
        wait_drain();
        check("sat_no_clamp", sat_count, exp_sat);
        send_exp(24'h0000FF, 2'd0, 1'b0, 24'hFF554C, 1'b1);
        wait_drain();
        check("sat_after_red", sat_count, exp_sat);
        send_exp(24'hFF0000, 2'd1, 1'b0, 24'h74FF12, 1'b1);
        send_exp(24'h123456, 2'd2, 1'b1, 24'h123456, 1'b0);
        send_exp(24'h654321, 2'd3, 1'b0, 24'h654321, 1'b0);
        wait_drain();
        check("sat_directed", sat_count, exp_sat);

        // Random stream: mixed modes, input bubbles, random backpressure
        lat_exact  = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_model(24'($urandom()), 2'($urandom_range(0, 3)), (i % 8) == 7);
        end
        wait_drain();
        check("sat_random", sat_count, exp_sat);

        // Asynchronous reset with three pixels in flight
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        lat_exact = 1'b1;
        send_model(24'($urandom()), 2'd0, 1'b0);
        send_model(24'($urandom()), 2'd1, 1'b1);
        send_model(24'($urandom()), 2'd2, 1'b0);
        check("inflight_m_valid", bus.m_valid, 1);
        exp_q.delete();
        exp_sat = 0;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", bus.m_valid, 0);
        check("async_rst_m_data", bus.m_data, 0);
        check("async_rst_m_last", bus.m_last, 0);
        check("async_rst_s_ready", bus.s_ready, 1);
        check("async_rst_sat", sat_count, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_m_valid", bus.m_valid, 0);
        end
        @(posedge clk);
        #1;
        send_model(24'h0000FF, 2'd0, 1'b1);
        wait_drain();
        check("sat_post_reset", sat_count, exp_sat);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
